// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error capture: latches the first violation report into the
// ERR_REQ* record, raises the error interrupt and counts later reports.
package rv_iopmp_pkg;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2,
    ACC_EXEC  = 2'd3
  } access_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_CLEAR = 2'd2
  } cap_state_t;

  localparam logic [2:0] ERR_NOHIT = 3'd5;

endpackage

module rv_iopmp_err_capture
  import rv_iopmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SID_WIDTH  = 8,
  parameter int EIDX_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  err_valid_i,
  output logic                  err_ready_o,
  input  logic [2:0]            err_type_i,
  input  logic [EIDX_WIDTH-1:0] err_eid_i,
  input  logic [ADDR_WIDTH-1:0] err_addr_i,
  input  logic [SID_WIDTH-1:0]  err_sid_i,
  input  logic [1:0]            err_ttype_i,
  input  logic                  cfg_ie_i,
  input  logic                  cfg_nohit_supp_i,
  input  logic                  sw_clear_i,
  output logic                  rec_valid_o,
  output logic [2:0]            rec_type_o,
  output logic [1:0]            rec_ttype_o,
  output logic [EIDX_WIDTH-1:0] rec_eid_o,
  output logic [ADDR_WIDTH-1:0] rec_addr_o,
  output logic [SID_WIDTH-1:0]  rec_sid_o,
  output logic [CNT_WIDTH-1:0]  rec_drop_cnt_o,
  output logic                  irq_o
);

  cap_state_t            state;
  logic [2:0]            typ;
  access_t               ttype;
  logic [EIDX_WIDTH-1:0] eid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [SID_WIDTH-1:0]  sid;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  irq;

  logic ready;
  logic accept;
  logic supp;
  logic take;
  logic cnt_full;

  assign ready    = (state != ST_CLEAR);
  assign accept   = err_valid_i & ready;
  assign supp     = cfg_nohit_supp_i
                  & (err_type_i == ERR_NOHIT);
  assign take     = accept & ~supp;
  assign cnt_full = &cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      typ   <= '0;
      ttype <= ACC_NONE;
      eid   <= '0;
      addr  <= '0;
      sid   <= '0;
      cnt   <= '0;
      irq   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          irq <= 1'b0;
          if (take) begin
            state <= ST_HELD;
            typ   <= err_type_i;
            ttype <= access_t'(err_ttype_i);
            eid   <= err_eid_i;
            addr  <= err_addr_i;
            sid   <= err_sid_i;
            irq   <= cfg_ie_i;
          end
        end
        ST_HELD: begin
          // clear beats a same-cycle report; that report is lost
          if (sw_clear_i) begin
            state <= ST_CLEAR;
            typ   <= '0;
            ttype <= ACC_NONE;
            eid   <= '0;
            addr  <= '0;
            sid   <= '0;
            cnt   <= '0;
            irq   <= 1'b0;
          end else begin
            irq <= cfg_ie_i;
            if (take && !cnt_full) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  assign err_ready_o    = ready;
  assign rec_valid_o    = (state == ST_HELD);
  assign rec_type_o     = typ;
  assign rec_ttype_o    = ttype;
  assign rec_eid_o      = eid;
  assign rec_addr_o     = addr;
  assign rec_sid_o      = sid;
  assign rec_drop_cnt_o = cnt;
  assign irq_o          = irq;

endmodule
